// File: rtl/fp32_add_issue.sv
// Issue stage for a free-running fp32 adder: credit-gated operand accept, valid tracking, result FIFO.
// Optional feature macro FP32_ADD_ISSUE_EXC_EN adds a stored exponent-all-ones flag (out_exc).
module fp32_add_issue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LAT   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        add_en,
  output logic [31:0] add_x1,
  output logic [31:0] add_x2,
  input  logic [31:0] add_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
`ifdef FP32_ADD_ISSUE_EXC_EN
  output logic        out_exc,
`endif
  output logic        busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
`ifdef FP32_ADD_ISSUE_EXC_EN
  localparam int unsigned W = 33;
`else
  localparam int unsigned W = 32;
`endif

  logic [LAT-1:0] r_vld_sr;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  // Credits in use: results in flight plus results queued; bounds the FIFO fill.
  logic [CW-1:0]  r_used;
  logic [W-1:0]   r_mem [DEPTH];

  logic           w_fire;
  logic           w_cap;
  logic           w_pop;
  logic [W-1:0]   w_wdata;

  assign add_en   = 1'b1;
  assign add_x1   = in_a;
  assign add_x2   = in_b;

  assign in_ready = !rst && (r_used < CW'(DEPTH));
  assign w_fire   = in_valid & in_ready;
  assign w_cap    = r_vld_sr[LAT-1];
  assign w_pop    = out_valid & out_ready;

`ifdef FP32_ADD_ISSUE_EXC_EN
  assign w_wdata  = {add_y[30:23] == 8'hFF, add_y};
  assign out_exc  = r_mem[r_rptr][32];
`else
  assign w_wdata  = add_y;
`endif

  assign out_valid = (r_count != '0);
  assign out_sum   = r_mem[r_rptr][31:0];
  assign busy      = (r_used != '0);

  generate
    if (LAT == 1) begin : g_sr_one
      always_ff @(posedge clk) begin
        if (rst) r_vld_sr <= '0;
        else     r_vld_sr <= w_fire;
      end
    end else begin : g_sr_multi
      always_ff @(posedge clk) begin
        if (rst) r_vld_sr <= '0;
        else     r_vld_sr <= {r_vld_sr[LAT-2:0], w_fire};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_used  <= '0;
    end else begin
      if (w_cap) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;

      case ({w_cap, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A capture only moves a credit from in-flight to queued, so it does not change r_used.
      case ({w_fire, w_pop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_cap) r_mem[r_wptr] <= w_wdata;
  end

endmodule

// File: tb/tb_fp32_add_issue.sv
// Scoreboard bench for fp32_add_issue with a LAT-deep behavioural fp32 adder model.
module tb_fp32_add_issue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        add_en;
  logic [31:0] add_x1;
  logic [31:0] add_x2;
  logic [31:0] add_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
`ifdef FP32_ADD_ISSUE_EXC_EN
  logic        out_exc;
`endif
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] y_pipe [LAT];

  always #5 clk = ~clk;

  fp32_add_issue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_en    (add_en),
    .add_x1    (add_x1),
    .add_x2    (add_x2),
    .add_y     (add_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef FP32_ADD_ISSUE_EXC_EN
    .out_exc   (out_exc),
`endif
    .busy      (busy)
  );

  function automatic real fp32_to_real(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    if (b[30:23] == 8'hFF) d = {b[31], 11'h7FF, b[22:0], 29'd0};
    else                   d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp32(input real x);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(x);
    if (d[62:0] == 63'd0) return 32'd0;
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
  endfunction

  function automatic logic [31:0] int_to_fp32(input int unsigned n);
    return real_to_fp32(real'(n));
  endfunction

  // Behavioural adder: operands sampled at edge E appear on add_y for sampling at edge E+LAT.
  always @(posedge clk) begin
    if (add_en) begin
      y_pipe[0] <= fp_add(add_x1, add_x2);
      for (int i = 1; i < LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
  end
  assign add_y = y_pipe[LAT-1];

  // One clock: sample handshakes mid-cycle, update the scoreboard, advance past the edge.
  task automatic tick(output logic fired, output logic popped, output logic [32:0] got,
                      output logic [31:0] exp_v, output logic had_exp);
    @(negedge clk);
    fired  = in_valid && in_ready;
    popped = out_valid && out_ready;
    got    = {1'b0, out_sum};
`ifdef FP32_ADD_ISSUE_EXC_EN
    got[32] = out_exc;
`endif
    had_exp = 1'b0;
    exp_v   = 32'd0;
    if (popped && exp_q.size() > 0) begin
      exp_v   = exp_q.pop_front();
      had_exp = 1'b1;
    end
    if (fired) exp_q.push_back(fp_add(in_a, in_b));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic f, p, he;
    logic [32:0] g;
    logic [31:0] e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    for (int i = 0; i < 3; i++) tick(f, p, g, e, he);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    tick(f, p, g, e, he);
  endtask

  task automatic test_basic();
    logic f, p, he;
    logic [32:0] g;
    logic [31:0] e;
    int fire_cyc = -1;
    int seen_cyc = -1;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; out_ready = 1'b1;
    for (int i = 0; i < 4 * LAT + 10; i++) begin
      tick(f, p, g, e, he);
      in_valid = 1'b0;
      if (f && fire_cyc < 0) fire_cyc = cyc;
      if (p) begin
        seen_cyc = cyc;
        checks++;
        if (g[31:0] !== 32'h40400000 || !he || e !== 32'h40400000) begin
          errors++; $display("FAIL basic_sum: got %h expected 40400000", g[31:0]);
        end
        break;
      end
    end
    checks++;
    if (fire_cyc < 0) begin errors++; $display("FAIL basic_fire: got no fire expected one"); end
    // The edge that pops the result is LAT+1 edges after the fire edge.
    checks++;
    if (seen_cyc - fire_cyc != int'(LAT) + 1) begin
      errors++; $display("FAIL basic_latency: got %0d expected %0d", seen_cyc - fire_cyc, LAT + 1);
    end
  endtask

  task automatic test_backpressure();
    logic f, p, he;
    logic [32:0] g;
    logic [31:0] e;
    logic [31:0] a [12];
    logic [31:0] b [12];
    int idx = 0;
    int pops = 0;
    int early_pops = 0;
    for (int i = 0; i < 12; i++) begin
      a[i] = int_to_fp32(i + 1);
      b[i] = int_to_fp32(2 * i + 3);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 12 + LAT + 4; i++) begin
      in_valid = (idx < 12); in_a = a[idx % 12]; in_b = b[idx % 12];
      tick(f, p, g, e, he);
      if (f) idx++;
      if (p) early_pops++;
    end
    checks++;
    if (idx != int'(DEPTH)) begin errors++; $display("FAIL bp_fires: got %0d expected %0d", idx, DEPTH); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (early_pops != 0) begin errors++; $display("FAIL bp_no_pop: got %0d expected 0", early_pops); end
    out_ready = 1'b1;
    for (int i = 0; i < 300 && pops < 12; i++) begin
      in_valid = (idx < 12); in_a = a[idx % 12]; in_b = b[idx % 12];
      tick(f, p, g, e, he);
      if (f) idx++;
      if (p) begin
        pops++;
        checks++;
        if (!he || g[31:0] !== e) begin
          errors++; $display("FAIL bp_order: got %h expected %h", g[31:0], e);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pops != 12) begin errors++; $display("FAIL bp_pops: got %0d expected 12", pops); end
  endtask

  task automatic test_stream();
    logic f, p, he, v;
    logic [32:0] g;
    logic [31:0] e;
    int sent = 0, pops = 0, stalls = 0, bubbles = 0;
    logic started = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 + 4 * LAT + 20 && pops < 100; i++) begin
      v = (sent < 100);
      in_valid = v; in_a = int_to_fp32(sent * 3 + 7); in_b = int_to_fp32(sent + 1);
      tick(f, p, g, e, he);
      if (v && !f) stalls++;
      if (f) sent++;
      if (p) begin
        started = 1'b1;
        pops++;
        checks++;
        if (!he || g[31:0] !== e) begin
          errors++; $display("FAIL stream_order: got %h expected %h", g[31:0], e);
        end
      end else if (started) begin
        bubbles++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    checks++;
    if (bubbles != 0) begin errors++; $display("FAIL stream_bubbles: got %0d expected 0", bubbles); end
    checks++;
    if (pops != 100) begin errors++; $display("FAIL stream_pops: got %0d expected 100", pops); end
  endtask

  task automatic test_random();
    logic f, p, he;
    logic [32:0] g;
    logic [31:0] e;
    int sent = 0, pops = 0, extra = 0;
    for (int i = 0; i < 20000 && pops < 1000; i++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      in_a = int_to_fp32($urandom_range(0, 1 << 20));
      in_b = int_to_fp32($urandom_range(0, 1 << 20));
      tick(f, p, g, e, he);
      if (f) sent++;
      if (p) begin
        pops++;
        checks++;
        if (!he || g[31:0] !== e) begin
          errors++; $display("FAIL rand_order: got %h expected %h", g[31:0], e);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2 * LAT + 4; i++) begin
      tick(f, p, g, e, he);
      if (p) extra++;
    end
    checks++;
    if (pops != 1000) begin errors++; $display("FAIL rand_pops: got %0d expected 1000", pops); end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL rand_duplicate: got %0d extra expected 0", extra); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_lost: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midflight();
    logic f, p, he;
    logic [32:0] g;
    logic [31:0] e;
    int fires = 0, stale = 0;
    logic got_fresh = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_a = int_to_fp32(100 + i); in_b = int_to_fp32(1);
      tick(f, p, g, e, he);
      if (f) fires++;
    end
    in_valid = 1'b0;
    // Four results now queued, three still in the adder.
    for (int i = 0; i < LAT - 3; i++) tick(f, p, g, e, he);
    checks++;
    if (fires != 7 || out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rmf_setup: got fires=%0d ov=%b busy=%b expected 7 1 1",
                         fires, out_valid, busy);
    end
    rst = 1'b1;
    tick(f, p, g, e, he);
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b expected 0", busy); end
    out_ready = 1'b1;
    for (int i = 0; i < 3 * LAT + 5; i++) begin
      tick(f, p, g, e, he);
      if (p) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL rmf_stale: got %0d pops expected 0", stale); end
    in_valid = 1'b1; in_a = int_to_fp32(5); in_b = int_to_fp32(6);
    tick(f, p, g, e, he);
    in_valid = 1'b0;
    for (int i = 0; i < 4 * LAT + 10 && !got_fresh; i++) begin
      tick(f, p, g, e, he);
      if (p) begin
        got_fresh = 1'b1;
        checks++;
        if (!he || g[31:0] !== 32'h41300000) begin
          errors++; $display("FAIL rmf_fresh: got %h expected 41300000", g[31:0]);
        end
      end
    end
    checks++;
    if (!got_fresh) begin errors++; $display("FAIL rmf_fresh_timeout: got none expected one"); end
  endtask

`ifdef FP32_ADD_ISSUE_EXC_EN
  task automatic test_exc();
    logic f, p, he;
    logic [32:0] g;
    logic [31:0] e;
    logic [31:0] xa [2];
    logic [31:0] xs [2];
    logic        xf [2];
    xa[0] = 32'h7F800000; xs[0] = 32'h7F800000; xf[0] = 1'b1;
    xa[1] = 32'h3F800000; xs[1] = 32'h40000000; xf[1] = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic done = 1'b0;
      in_valid = 1'b1; in_a = xa[k]; in_b = 32'h3F800000;
      tick(f, p, g, e, he);
      in_valid = 1'b0;
      for (int i = 0; i < 4 * LAT + 10 && !done; i++) begin
        tick(f, p, g, e, he);
        if (p) begin
          done = 1'b1;
          checks++;
          if (g[31:0] !== xs[k]) begin
            errors++; $display("FAIL exc_sum: got %h expected %h", g[31:0], xs[k]);
          end
          checks++;
          if (g[32] !== xf[k]) begin
            errors++; $display("FAIL exc_flag: got %b expected %b", g[32], xf[k]);
          end
        end
      end
      checks++;
      if (!done) begin errors++; $display("FAIL exc_timeout: got none expected one"); end
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_midflight();
`ifdef FP32_ADD_ISSUE_EXC_EN
    test_exc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
